// File: rtl/arm_pkg.sv
// Shared ARM definitions: default memory depths and the boot loader state encoding.
// Used by the ARM top level, the memories and the memory loader.
package arm_pkg;

    localparam int unsigned ARM_INS_MEM_SIZE  = 32;
    localparam int unsigned ARM_DATA_MEM_SIZE = 64;

    typedef enum logic [1:0] {
        LOAD_INS  = 2'd0,
        LOAD_DATA = 2'd1,
        RUN       = 2'd2
    } loader_state_t;

endpackage

// File: rtl/arm_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; the completed word is
// presented combinationally alongside the 4th byte so the caller can register it on that edge.
module arm_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane;
    logic [23:0] low_bytes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane      <= '0;
            low_bytes <= '0;
        end else if (clear) begin
            lane      <= '0;
            low_bytes <= '0;
        end else if (accept) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    low_bytes[7:0]   <= byte_in;
                2'd1:    low_bytes[15:8]  <= byte_in;
                2'd2:    low_bytes[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    // Lane 3 never lands in low_bytes: it is the top byte of the word being emitted.
    always_comb begin
        word       = {byte_in, low_bytes};
        word_valid = accept & ~clear & (lane == 2'd3);
    end

endmodule

// File: rtl/arm_mem_loader.sv
// Boot-time loader: fills instruction memory then data memory from a byte stream,
// holding the ARM core in reset until both are loaded.
module arm_mem_loader
    import arm_pkg::*;
#(
    parameter int unsigned INS_MEM_SIZE  = ARM_INS_MEM_SIZE,
    parameter int unsigned DATA_MEM_SIZE = ARM_DATA_MEM_SIZE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             restart,
    input  logic                             in_valid,
    input  logic [7:0]                       in_data,
    output logic                             in_ready,
    output logic                             ins_we,
    output logic [$clog2(INS_MEM_SIZE)-1:0]  ins_addr,
    output logic [31:0]                      ins_wdata,
    output logic                             data_we,
    output logic [$clog2(DATA_MEM_SIZE)-1:0] data_addr,
    output logic [31:0]                      data_wdata,
    output logic                             core_rst,
    output logic                             done
);

    localparam int unsigned IAW = $clog2(INS_MEM_SIZE);
    localparam int unsigned DAW = $clog2(DATA_MEM_SIZE);
    localparam int unsigned CW  = (IAW > DAW) ? IAW : DAW;
    localparam logic [CW-1:0] INS_LAST  = CW'(INS_MEM_SIZE - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_MEM_SIZE - 1);

    loader_state_t state, state_next;
    logic [CW-1:0] word_idx, word_idx_next;
    logic          accept;
    logic          word_valid;
    logic [31:0]   word;
    logic          ins_wr;
    logic          data_wr;

    arm_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clear      (restart),
        .accept     (accept),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOAD_INS;
            word_idx <= '0;
        end else begin
            state    <= state_next;
            word_idx <= word_idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        word_idx_next = word_idx;
        if (restart) begin
            state_next    = LOAD_INS;
            word_idx_next = '0;
        end else if (word_valid) begin
            case (state)
                LOAD_INS: begin
                    if (word_idx == INS_LAST) begin
                        state_next    = LOAD_DATA;
                        word_idx_next = '0;
                    end else begin
                        word_idx_next = word_idx + 1'b1;
                    end
                end
                LOAD_DATA: begin
                    if (word_idx == DATA_LAST) begin
                        state_next    = RUN;
                        word_idx_next = '0;
                    end else begin
                        word_idx_next = word_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready = (state != RUN);
        accept   = in_valid & in_ready;
        ins_wr   = word_valid & ~restart & (state == LOAD_INS);
        data_wr  = word_valid & ~restart & (state == LOAD_DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ins_we     <= 1'b0;
            ins_addr   <= '0;
            ins_wdata  <= '0;
            data_we    <= 1'b0;
            data_addr  <= '0;
            data_wdata <= '0;
            core_rst   <= 1'b1;
        end else begin
            ins_we  <= ins_wr;
            data_we <= data_wr;
            if (ins_wr) begin
                ins_addr  <= word_idx[IAW-1:0];
                ins_wdata <= word;
            end
            if (data_wr) begin
                data_addr  <= word_idx[DAW-1:0];
                data_wdata <= word;
            end
            // Sampling the pre-edge state delays core release by one cycle after the last write.
            core_rst <= restart | (state != RUN);
        end
    end

    assign done = ~core_rst;

endmodule
